// File: rtl/linea_serializer.sv
// Parallel-to-serial feeder for the LINEA line-pattern FSM: MSB-first shift-out with an idle gap per word.
// Optional even-parity bit after the LSB when LINEA_PARITY_EN is defined.
module linea_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP        = 2,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             LINEA,
    output logic             busy,
    output logic [7:0]       words_sent
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
`ifdef LINEA_PARITY_EN
        , ST_PAR = 2'd3
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bitcnt;
    logic [GAP_W-1:0] gapcnt;
    logic             word_end_c;

`ifdef LINEA_PARITY_EN
    logic par_q;

    // Parity is captured at accept because the shift register is consumed while sending.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            par_q <= 1'b0;
        end else if (state == ST_IDLE && din_valid) begin
            par_q <= ^din;
        end
    end

    assign word_end_c = (state == ST_PAR);
`else
    assign word_end_c = (state == ST_SHIFT) && (bitcnt == '0);
`endif

    assign din_ready = resetn & (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            LINEA      <= IDLE_LEVEL;
            shreg      <= '0;
            bitcnt     <= '0;
            gapcnt     <= '0;
            words_sent <= '0;
        end else if (word_end_c) begin
            LINEA      <= IDLE_LEVEL;
            words_sent <= words_sent + 8'd1;
            if (GAP != 0) begin
                state  <= ST_GAP;
                gapcnt <= GAP_W'(GAP - 1);
            end else begin
                state  <= ST_IDLE;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (din_valid) begin
                        LINEA  <= din[WIDTH-1];
                        shreg  <= din << 1;
                        bitcnt <= CNT_W'(WIDTH - 1);
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bitcnt != '0) begin
                        LINEA  <= shreg[WIDTH-1];
                        shreg  <= shreg << 1;
                        bitcnt <= bitcnt - CNT_W'(1);
                    end
`ifdef LINEA_PARITY_EN
                    else begin
                        LINEA <= par_q;
                        state <= ST_PAR;
                    end
`endif
                end
                ST_GAP: begin
                    if (gapcnt == '0) begin
                        state  <= ST_IDLE;
                    end else begin
                        gapcnt <= gapcnt - GAP_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_linea_serializer.sv
// Bench for linea_serializer: default instance (WIDTH=8, GAP=2) plus a GAP=0 instance,
// checked cycle by cycle against a word-level model of the expected line waveform.
module tb_linea_serializer;

    localparam int unsigned W    = 8;
    localparam int unsigned GAPV = 2;
    localparam logic        IDLE = 1'b1;
`ifdef LINEA_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif

    logic         clock = 1'b0;
    logic         resetn;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         LINEA;
    logic         busy;
    logic [7:0]   words_sent;

    logic [W-1:0] din0;
    logic         din_valid0;
    logic         ready0;
    logic         linea0;
    logic         busy0;
    logic [7:0]   ws0;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   ws_exp = 8'd0;

    linea_serializer #(.WIDTH(W), .GAP(GAPV), .IDLE_LEVEL(IDLE)) dut (
        .clock(clock), .resetn(resetn), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .LINEA(LINEA), .busy(busy), .words_sent(words_sent)
    );

    linea_serializer #(.WIDTH(W), .GAP(0), .IDLE_LEVEL(IDLE)) dut0 (
        .clock(clock), .resetn(resetn), .din(din0), .din_valid(din_valid0),
        .din_ready(ready0), .LINEA(linea0), .busy(busy0), .words_sent(ws0)
    );

    always #5 clock = ~clock;

    // Line level expected in the cycle after edge e(k) for a word accepted at e0.
    function automatic logic exp_bit(input logic [W-1:0] w, input int k);
        logic [W-1:0] t;
        if (k < int'(W)) begin
            t = w << k;
            return t[W-1];
        end
        if (P == 1 && k == int'(W)) return ^w;
        return IDLE;
    endfunction

    task automatic apply_reset();
        resetn = 1'b0; din_valid = 1'b0; din_valid0 = 1'b0; din = '0; din0 = '0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        ws_exp = 8'd0;
    endtask

    // Sends one word on the main instance starting at a negedge with the DUT idle.
    task automatic run_word(input logic [W-1:0] w, input bit noise, input bit keep_valid);
        int last;
        logic [7:0] ws_want;
        last = int'(W + P + GAPV);
        checks++;
        if (din_ready !== 1'b1) begin
            errors++; $display("FAIL ready_before_accept: got %b want 1", din_ready);
        end
        din = w; din_valid = 1'b1;
        for (int k = 0; k <= last; k++) begin
            @(posedge clock); @(negedge clock);
            checks++;
            if (LINEA !== exp_bit(w, k)) begin
                errors++; $display("FAIL linea word=%h k=%0d: got %b want %b", w, k, LINEA, exp_bit(w, k));
            end
            checks++;
            if (din_ready !== (k == last)) begin
                errors++; $display("FAIL din_ready word=%h k=%0d: got %b want %b", w, k, din_ready, (k == last));
            end
            checks++;
            if (busy !== (k != last)) begin
                errors++; $display("FAIL busy word=%h k=%0d: got %b want %b", w, k, busy, (k != last));
            end
            ws_want = (k >= int'(W + P)) ? ws_exp + 8'd1 : ws_exp;
            checks++;
            if (words_sent !== ws_want) begin
                errors++; $display("FAIL words_sent word=%h k=%0d: got %0d want %0d", w, k, words_sent, ws_want);
            end
            if (k == last) begin
                din_valid = keep_valid;
            end else if (noise) begin
                din = W'($urandom); din_valid = 1'($urandom);
            end else begin
                din_valid = keep_valid;
            end
        end
        ws_exp = ws_exp + 8'd1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; din_valid = 1'b1; din = 8'hFF; din_valid0 = 1'b1; din0 = 8'h00;
        repeat (2) @(negedge clock);
        checks++;
        if (LINEA !== IDLE || linea0 !== IDLE) begin
            errors++; $display("FAIL reset_linea: got %b/%b want %b", LINEA, linea0, IDLE);
        end
        checks++;
        if (din_ready !== 1'b0 || ready0 !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b/%b want 0", din_ready, ready0);
        end
        checks++;
        if (busy !== 1'b0 || words_sent !== 8'd0) begin
            errors++; $display("FAIL reset_state: busy %b words %0d want 0 0", busy, words_sent);
        end
        din_valid = 1'b0; din_valid0 = 1'b0;
        resetn = 1'b1;
        @(negedge clock);
        checks++;
        if (din_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL after_reset: ready %b busy %b want 1 0", din_ready, busy);
        end
        ws_exp = 8'd0;
    endtask

    task automatic test_reset_mid_word();
        din = 8'hF0; din_valid = 1'b1;
        @(posedge clock); @(negedge clock);
        din_valid = 1'b0;
        repeat (4) begin
            @(posedge clock); @(negedge clock);
        end
        checks++;
        if (LINEA !== 1'b0) begin
            errors++; $display("FAIL mid_word_bit4: got %b want 0", LINEA);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (LINEA !== IDLE || din_ready !== 1'b0) begin
            errors++; $display("FAIL async_reset: linea %b ready %b want %b 0", LINEA, din_ready, IDLE);
        end
        checks++;
        if (busy !== 1'b0 || words_sent !== 8'd0) begin
            errors++; $display("FAIL async_reset_state: busy %b words %0d want 0 0", busy, words_sent);
        end
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        ws_exp = 8'd0;
        run_word(8'h0F, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        run_word(8'hA5, 1'b0, 1'b0);
        run_word(8'h07, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_word(8'hFF, 1'b0, 1'b1);
        run_word(8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_busy();
        run_word(8'h3C, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int n;
        n = 20;
        for (int i = 0; i < n; i++) begin
            run_word(W'($urandom), 1'($urandom), (i != n - 1) && 1'($urandom));
        end
    endtask

    task automatic test_gap0();
        int last;
        last = int'(W + P);
        din0 = 8'h81; din_valid0 = 1'b1;
        for (int wd = 0; wd < 2; wd++) begin
            for (int k = 0; k <= last; k++) begin
                @(posedge clock); @(negedge clock);
                checks++;
                if (linea0 !== exp_bit(8'h81, k)) begin
                    errors++; $display("FAIL gap0_linea w%0d k=%0d: got %b want %b", wd, k, linea0, exp_bit(8'h81, k));
                end
                checks++;
                if (ready0 !== (k == last) || busy0 !== (k != last)) begin
                    errors++; $display("FAIL gap0_ready w%0d k=%0d: ready %b busy %b", wd, k, ready0, busy0);
                end
                if (k == last) din_valid0 = (wd == 0);
            end
        end
        checks++;
        if (ws0 !== 8'd2) begin
            errors++; $display("FAIL gap0_words: got %0d want 2", ws0);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            run_word(W'($urandom), 1'b0, i != 255);
        end
        checks++;
        if (words_sent !== 8'd0) begin
            errors++; $display("FAIL wrap: got %0d want 0", words_sent);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_word();
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_gap0();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/linea_serializer.md
Name: linea_serializer

Overview:
- Upstream feeder for the serial line-pattern FSM: converts parallel words into the single-bit LINEA stream that the FSM samples every clock.
- Words enter on a valid/ready handshake and are shifted out MSB-first.
- After each word the line is held at a fixed idle level for a programmable gap.
- Provides a busy flag and a sent-word counter for system bookkeeping and formal properties.

Parameters:
- WIDTH, 8, bits per word; legal range 2..16.
- GAP, 2, extra idle-level cycles after the last data bit; legal range 0..15.
- IDLE_LEVEL, 1, value driven on LINEA whenever no data bit is being sent.

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- resetn  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word; sampled only on an accepted handshake.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  serializer can accept a word this cycle.
- LINEA  output  1  registered serial line output.
- busy  output  1  high whenever state != IDLE.
- words_sent  output  8  count of completed words; wraps 255->0.

Behaviour:
- Reset (resetn low, asynchronous, takes effect immediately):
  - state=IDLE, LINEA=IDLE_LEVEL, shift register=0, bit and gap counters=0, words_sent=0.
  - din_ready=0 while resetn is low.
  - A reset mid-word aborts that word; it is not replayed and not counted.
- States: IDLE, SHIFT, GAP (plus PAR with the option below).
- din_ready = resetn & (state==IDLE). It is combinational from state only and does not depend on din_valid.
- Accept at posedge edge e0 when din_valid & din_ready:
  - LINEA<=din[WIDTH-1]; shreg<=din<<1; bitcnt<=WIDTH-1; state<=SHIFT.
- SHIFT:
  - Each edge with bitcnt!=0: LINEA<=shreg[MSB], shift left, bitcnt-1.
  - Result: bit i of the word (MSB=i0) is on LINEA during the cycle after edge e(i).
- Edge eW, where bitcnt==0 in SHIFT:
  - LINEA<=IDLE_LEVEL and words_sent+1.
  - state<=GAP with gapcnt<=GAP-1 if GAP>0, else state<=IDLE.
- GAP: LINEA holds IDLE_LEVEL; gapcnt decrements each edge; at gapcnt==0 go to IDLE.
- Timing:
  - LINEA sits at IDLE_LEVEL for GAP+1 cycles between consecutive words.
  - The earliest next accept is edge e(WIDTH+GAP+1).
- din_valid while busy: ignored, no backpressure error; din may change freely.
- din_valid may drop before acceptance without any sticky effect.
- Simultaneous reset and handshake: reset wins.
- words_sent arithmetic is modulo 256.
- LINEA is always a flop output, with no combinational path from din.

Optional Feature:
- Macro LINEA_PARITY_EN.
- Defined:
  - After the LSB, state PAR drives one even-parity bit on LINEA for one cycle (XOR of the WIDTH data bits).
  - The XOR of all WIDTH+1 transmitted bits is therefore 0.
  - words_sent increments at the edge ending the parity cycle.
  - GAP follows the parity cycle; the earliest next accept is e(WIDTH+GAP+2).
- Undefined: no PAR state and no parity bit; timing as above.

Test Plan:
- Reset mid-word: send 8'hF0, pull resetn low after bit 3 -> LINEA=1 and din_ready=0 immediately, words_sent=0. Release, send 8'h0F -> bits 0,0,0,0,1,1,1,1 with no residue from the aborted word.
- Single word: WIDTH=8, GAP=2, IDLE_LEVEL=1, accept 8'hA5 at e0 -> LINEA=1,0,1,0,0,1,0,1 on cycles after e0..e7. Then 1 for 3 cycles, words_sent=1, din_ready high again in the cycle after e10.
- Back-to-back: din_valid held high with 8'hFF then 8'h00 -> second accept exactly at e11. Between the words LINEA is high for 3 cycles, i.e. 11 consecutive 1s in total. words_sent=2, busy never low for more than 1 cycle.
- Ignore while busy: toggle din/din_valid during SHIFT of 8'h3C -> only 8'h3C appears, and din_ready stays 0 until IDLE.
- GAP=0 variant: two back-to-back words 8'h81 -> exactly one idle-level cycle between them; next accept at e9.
- Wrap and parity:
  - Send 256 words -> words_sent returns to 0.
  - With LINEA_PARITY_EN, 8'h07 -> parity bit 1 after the LSB, and the next accept occurs at e12 with GAP=2.
